// File: rtl/onehot_dec_pkg.sv
// Shared state encoding and mode constants for the registered one-hot decoder.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec_dwell.sv
// Loadable down-counter that times how long the scan holds each output position.
module onehot_dec_dwell #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input and walking-one scan mode.
// Define ONEHOT_DEC_ACTIVE_LOW_EN to drive out one-cold (idle value all-ones).
module onehot_decoder_seq
    import onehot_dec_pkg::*;
#(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 mode,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_addr,
    output logic [2**ADDR_W-1:0] out,
    output logic                 out_valid,
    output logic                 scan_wrap
);

    localparam int unsigned OUT_W = 2**ADDR_W;

    dec_state_t       state;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic             scan_wrap_q;

    logic xfer;
    logic scan_go;
    logic scan_run;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    assign in_ready = en & (mode == MODE_DIRECT) & ~clr & rst_n & (state != SCAN);
    assign xfer     = in_valid & in_ready;

    assign scan_go  = en & ~clr & (mode == MODE_SCAN) & (state != SCAN);
    assign scan_run = en & ~clr & (mode == MODE_SCAN) & (state == SCAN);

    // dwell is sampled only on entry and at each step, so mid-hold changes wait for the next step
    assign cnt_load = scan_go | (scan_run & cnt_zero);
    assign cnt_dec  = scan_run & ~cnt_zero;

    onehot_dec_dwell #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (dwell),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else if (clr) begin
            state       <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else if (!en) begin
            scan_wrap_q <= 1'b0;
        end else begin
            scan_wrap_q <= 1'b0;
            unique case (state)
                IDLE, DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        state       <= SCAN;
                        out_q       <= OUT_W'(1);
                        out_valid_q <= 1'b1;
                    end else if (xfer) begin
                        state       <= DIRECT;
                        out_q       <= OUT_W'(1) << in_addr;
                        out_valid_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        state       <= IDLE;
                        out_q       <= '0;
                        out_valid_q <= 1'b0;
                    end else if (cnt_zero) begin
                        out_q       <= {out_q[OUT_W-2:0], out_q[OUT_W-1]};
                        scan_wrap_q <= out_q[OUT_W-1];
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
    assign out = ~out_q;
`else
    assign out = out_q;
`endif

    assign out_valid = out_valid_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed self-checking bench for onehot_decoder_seq (ADDR_W=3, DWELL_W=8).
module tb_onehot_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       mode;
    logic [7:0] dwell;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_addr;
    logic [7:0] out;
    logic       out_valid;
    logic       scan_wrap;

    int checks = 0;
    int errors = 0;

    onehot_decoder_seq #(
        .ADDR_W  (3),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .dwell     (dwell),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .out       (out),
        .out_valid (out_valid),
        .scan_wrap (scan_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] eo(input logic [7:0] v);
`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] o, input logic v, input logic w);
        chk({tag, ".out"}, 32'(out), 32'(eo(o)));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".wrap"}, 32'(scan_wrap), 32'(w));
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        clr      = 1'b0;
        mode     = 1'b0;
        dwell    = 8'd0;
        in_valid = 1'b1;
        in_addr  = 3'd5;

        // Reset held with a pending request
        repeat (3) step();
        chk_out("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.ready", 32'(in_ready), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("release.ready", 32'(in_ready), 32'd1);
        step();
        chk_out("release", 8'h00, 1'b0, 1'b0);

        // Direct, back-to-back
        in_valid = 1'b1;
        in_addr  = 3'd5;
        step();
        chk_out("dir5", 8'h20, 1'b1, 1'b0);
        in_addr = 3'd0;
        step();
        chk_out("dir0", 8'h01, 1'b1, 1'b0);
        in_addr = 3'd7;
        step();
        chk_out("dir7", 8'h80, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        chk_out("dirhold", 8'h80, 1'b1, 1'b0);

        // Scan with dwell=2: each position held 3 cycles, wrap after 24
        dwell = 8'd2;
        mode  = 1'b1;
        #1;
        chk("scan.ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 27; k++) begin
            step();
            chk_out($sformatf("scan2_%0d", k), 8'h01 << ((k / 3) % 8), 1'b1, k == 24);
        end

        // dwell=0 from here; current hold counter is already zero
        dwell = 8'd0;
        step();
        chk_out("scan0_02", 8'h02, 1'b1, 1'b0);
        step();
        chk_out("scan0_04", 8'h04, 1'b1, 1'b0);
        step();
        chk_out("scan0_08", 8'h08, 1'b1, 1'b0);

        // Freeze
        en = 1'b0;
        #1;
        chk("freeze.ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("freeze_%0d", k), 8'h08, 1'b1, 1'b0);
        end
        en = 1'b1;
        step();
        chk_out("unfreeze", 8'h10, 1'b1, 1'b0);
        step();
        chk_out("scan0_20", 8'h20, 1'b1, 1'b0);
        step();
        chk_out("scan0_40", 8'h40, 1'b1, 1'b0);

        // Clear mid-scan, then rescan from bit 0
        clr = 1'b1;
        #1;
        chk("clr.ready", 32'(in_ready), 32'd0);
        step();
        chk_out("clr", 8'h00, 1'b0, 1'b0);
        clr = 1'b0;
        step();
        chk_out("rescan_clr", 8'h01, 1'b1, 1'b0);
        step();
        chk_out("rescan_clr2", 8'h02, 1'b1, 1'b0);

        // Reset mid-scan, then rescan and wrap with dwell=0
        rst_n = 1'b0;
        step();
        chk_out("rst_mid", 8'h00, 1'b0, 1'b0);
        chk("rst_mid.ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk_out("rescan_rst", 8'h01, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step();
            chk_out($sformatf("walk_%0d", k), 8'h01 << k, 1'b1, 1'b0);
        end
        step();
        chk_out("wrap0", 8'h01, 1'b1, 1'b1);
        step();
        chk_out("postwrap", 8'h02, 1'b1, 1'b0);

        // Exit scan with a request pending: no transfer until IDLE
        mode     = 1'b0;
        in_valid = 1'b1;
        in_addr  = 3'd3;
        #1;
        chk("exit.ready", 32'(in_ready), 32'd0);
        step();
        chk_out("exit", 8'h00, 1'b0, 1'b0);
        chk("idle.ready", 32'(in_ready), 32'd1);
        step();
        chk_out("accept3", 8'h08, 1'b1, 1'b0);

        // Scan entry wins over a simultaneous request
        mode    = 1'b1;
        in_addr = 3'd2;
        #1;
        chk("collide.ready", 32'(in_ready), 32'd0);
        step();
        chk_out("collide", 8'h01, 1'b1, 1'b0);

        // Clear applies even while disabled
        en  = 1'b0;
        clr = 1'b1;
        step();
        chk_out("clr_noen", 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
